// File: rtl/mon_sopc_ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// mon_sopc_ram_arb_pkg
// Shared definitions for the mon_sopc on-chip RAM arbiter:
//   - RAM geometry (address/data/byte-enable widths, default depth)
//   - arbiter FSM state encoding
//   - next_rr(): round-robin winner search starting after the last winner
// ---------------------------------------------------------------------------
package mon_sopc_ram_arb_pkg;

  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int RAM_DEPTH_DEF = 5120;

  // Requester index width covers the largest legal NUM_REQ (4).
  localparam int MAX_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // Scan ptr+1, ptr+2, ... modulo num_req and return the first active index.
  // The last candidate is ptr itself, so a lone requester keeps winning.
  // With no active request the pointer is returned unchanged.
  function automatic logic [IDX_W-1:0] next_rr(
    input logic [MAX_REQ-1:0] req_vec,
    input logic [IDX_W-1:0]   ptr,
    input int                 num_req
  );
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % num_req;
      if ((k <= num_req) && !found && req_vec[idx]) begin
        win   = idx[IDX_W-1:0];
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mon_sopc_rr_pick.sv
// ---------------------------------------------------------------------------
// mon_sopc_rr_pick
// Purely combinational round-robin selector.
// Ports:
//   req_vec  in  NUM_REQ  active request per requester
//   ptr      in  IDX_W    index of the previous winner
//   winner   out IDX_W    first active index after ptr (modulo NUM_REQ)
//   any_req  out 1        at least one request active
// ---------------------------------------------------------------------------
module mon_sopc_rr_pick
  import mon_sopc_ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  logic [MAX_REQ-1:0] req_ext_s;

  // Widen the request vector to the package width and run the search.
  always_comb begin
    req_ext_s              = {MAX_REQ{1'b0}};
    req_ext_s[NUM_REQ-1:0] = req_vec;
    winner                 = next_rr(req_ext_s, ptr, NUM_REQ);
    any_req                = |req_vec;
  end

endmodule

// File: rtl/mon_sopc_ram_arbiter.sv
// ---------------------------------------------------------------------------
// mon_sopc_ram_arbiter
// Round-robin arbiter sharing the single-port on-chip RAM (13-bit word
// address, 32-bit data, 4 byte lanes) between NUM_REQ Avalon-MM requesters.
// One access is granted every two clocks: IDLE arbitrates, ISSUE forwards
// the granted requester's live command to the RAM. Read data returns one
// cycle after acceptance straight from the RAM output.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_address           NUM_REQ x 13  word address, requester i at [i*13+:13]
//   req_byteenable        NUM_REQ x 4   byte enables
//   req_writedata         NUM_REQ x 32  write data
//   req_read, req_write   NUM_REQ       command strobes
//   req_waitrequest       NUM_REQ       low only for the granted requester in ISSUE
//   req_readdatavalid     NUM_REQ       one-cycle read-return pulse
//   req_readdata          32            shared read data
//   ram_*                 RAM command outputs / readdata input
//   range_err             NUM_REQ       (MON_SOPC_RAM_ARB_RANGE_CHK_EN only)
//                                       sticky out-of-range access flag
//
// Optional feature macro: MON_SOPC_RAM_ARB_RANGE_CHK_EN
//   When defined, addresses >= RAM_DEPTH are accepted but not forwarded
//   (chipselect held low); such reads return zero data.
// ---------------------------------------------------------------------------
module mon_sopc_ram_arbiter
  import mon_sopc_ram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int RAM_DEPTH = RAM_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [BE_W-1:0]           ram_byteenable,
  output logic [DATA_W-1:0]         ram_writedata,
  output logic                      ram_chipselect,
  output logic                      ram_write,
  input  logic [DATA_W-1:0]         ram_readdata
`ifdef MON_SOPC_RAM_ARB_RANGE_CHK_EN
  ,
  output logic [NUM_REQ-1:0]        range_err
`endif
);

  arb_state_t         state_r;
  arb_state_t         state_nxt_s;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   winner_s;
  logic               any_req_s;
  logic [NUM_REQ-1:0] active_s;
  logic [NUM_REQ-1:0] rvalid_r;
  logic [ADDR_W-1:0]  g_addr_s;
  logic [BE_W-1:0]    g_be_s;
  logic [DATA_W-1:0]  g_wdata_s;
  logic               g_read_s;
  logic               g_write_s;
  logic               in_range_s;
  logic               accept_rd_s;

  assign active_s = req_read | req_write;

  mon_sopc_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_vec (active_s),
    .ptr     (rr_ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Select the granted requester's live command fields.
  always_comb begin
    g_addr_s  = req_address[grant_r*ADDR_W +: ADDR_W];
    g_be_s    = req_byteenable[grant_r*BE_W +: BE_W];
    g_wdata_s = req_writedata[grant_r*DATA_W +: DATA_W];
    g_read_s  = req_read[grant_r];
    g_write_s = req_write[grant_r];
  end

`ifdef MON_SOPC_RAM_ARB_RANGE_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(RAM_DEPTH);
  assign in_range_s = ({1'b0, g_addr_s} < DEPTH_L);
`else
  assign in_range_s = 1'b1;
`endif

  // A write with read also set wins; the read half is dropped.
  assign accept_rd_s = (state_r == ISSUE) && g_read_s && !g_write_s;

  // Next-state logic: IDLE arbitrates, ISSUE always lasts one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // RAM command and waitrequest, driven from the granted requester in ISSUE.
  always_comb begin
    ram_address     = g_addr_s;
    ram_byteenable  = g_be_s;
    ram_writedata   = g_wdata_s;
    ram_chipselect  = 1'b0;
    ram_write       = 1'b0;
    req_waitrequest = {NUM_REQ{1'b1}};
    if (state_r == ISSUE) begin
      ram_chipselect           = (g_read_s | g_write_s) & in_range_s;
      ram_write                = g_write_s;
      req_waitrequest[grant_r] = 1'b0;
    end else begin
      ram_chipselect  = 1'b0;
      ram_write       = 1'b0;
    end
  end

  // Reset also masks a valid pulse already in its return cycle.
  always_comb begin
    if (reset) begin
      req_readdatavalid = {NUM_REQ{1'b0}};
    end else begin
      req_readdatavalid = rvalid_r;
    end
  end

  // FSM state, grant/pointer and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      grant_r  <= {IDX_W{1'b0}};
      rr_ptr_r <= IDX_W'(NUM_REQ - 1);
      rvalid_r <= {NUM_REQ{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      rvalid_r <= {NUM_REQ{1'b0}};
      if ((state_r == IDLE) && any_req_s) begin
        grant_r  <= winner_s;
        rr_ptr_r <= winner_s;
      end
      if (accept_rd_s) begin
        rvalid_r[grant_r] <= 1'b1;
      end
    end
  end

`ifdef MON_SOPC_RAM_ARB_RANGE_CHK_EN
  logic               oor_rd_r;
  logic [NUM_REQ-1:0] range_err_r;

  // Out-of-range tracking: zero-data marker for the return cycle, sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      oor_rd_r    <= 1'b0;
      range_err_r <= {NUM_REQ{1'b0}};
    end else begin
      oor_rd_r <= accept_rd_s && !in_range_s;
      if ((state_r == ISSUE) && (g_read_s || g_write_s) && !in_range_s) begin
        range_err_r[grant_r] <= 1'b1;
      end
    end
  end

  assign range_err = range_err_r;

  // Read data pass-through, zeroed for an out-of-range read.
  always_comb begin
    if (oor_rd_r) begin
      req_readdata = {DATA_W{1'b0}};
    end else begin
      req_readdata = ram_readdata;
    end
  end
`else
  assign req_readdata = ram_readdata;
`endif

endmodule

// File: tb/tb_mon_sopc_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mon_sopc_ram_arbiter
// Directed bench for mon_sopc_ram_arbiter with two requesters and a small
// behavioural RAM (registered address, unregistered data output).
// ---------------------------------------------------------------------------
module tb_mon_sopc_ram_arbiter;

  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR*13-1:0] req_address;
  logic [NR*4-1:0]  req_byteenable;
  logic [NR*32-1:0] req_writedata;
  logic [NR-1:0]  req_read;
  logic [NR-1:0]  req_write;
  logic [NR-1:0]  req_waitrequest;
  logic [NR-1:0]  req_readdatavalid;
  logic [31:0]    req_readdata;
  logic [12:0]    ram_address;
  logic [3:0]     ram_byteenable;
  logic [31:0]    ram_writedata;
  logic           ram_chipselect;
  logic           ram_write;
  logic [31:0]    ram_readdata;
`ifdef MON_SOPC_RAM_ARB_RANGE_CHK_EN
  logic [NR-1:0]  range_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mon_sopc_ram_arbiter #(
    .NUM_REQ   (NR),
    .RAM_DEPTH (5120)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_address       (req_address),
    .req_byteenable    (req_byteenable),
    .req_writedata     (req_writedata),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_waitrequest   (req_waitrequest),
    .req_readdatavalid (req_readdatavalid),
    .req_readdata      (req_readdata),
    .ram_address       (ram_address),
    .ram_byteenable    (ram_byteenable),
    .ram_writedata     (ram_writedata),
    .ram_chipselect    (ram_chipselect),
    .ram_write         (ram_write),
    .ram_readdata      (ram_readdata)
`ifdef MON_SOPC_RAM_ARB_RANGE_CHK_EN
    ,
    .range_err         (range_err)
`endif
  );

  // Behavioural on-chip RAM.
  logic [31:0] mem [0:8191];
  logic [12:0] ram_addr_q = 13'd0;

  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
        end
      end
      ram_addr_q <= ram_address;
    end
  end

  assign ram_readdata = mem[ram_addr_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic rd, input logic wr,
                         input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    req_read[idx]              = rd;
    req_write[idx]             = wr;
    req_address[idx*13 +: 13]  = a;
    req_byteenable[idx*4 +: 4] = be;
    req_writedata[idx*32 +: 32] = d;
  endtask

  // Issue one command, wait (bounded) for acceptance, then check the response.
  task automatic do_access(input string tag, input int idx, input logic rd, input logic wr,
                           input logic [12:0] a, input logic [3:0] be, input logic [31:0] d,
                           input logic exp_cs, input logic [31:0] exp_rd);
    int n;
    logic [NR-1:0] exp_v;
    set_req(idx, rd, wr, a, be, d);
    n = 0;
    @(negedge clk);
    while ((req_waitrequest[idx] === 1'b1) && (n < 8)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, {31'd0, req_waitrequest[idx]}, 32'd0);
    chk({tag, "_cs"}, {31'd0, ram_chipselect}, {31'd0, exp_cs});
    chk({tag, "_ramwr"}, {31'd0, ram_write}, {31'd0, wr});
    tick();
    req_read[idx]  = 1'b0;
    req_write[idx] = 1'b0;
    @(negedge clk);
    exp_v = {NR{1'b0}};
    if (rd && !wr) exp_v[idx] = 1'b1;
    chk({tag, "_rdv"}, {30'd0, req_readdatavalid}, {30'd0, exp_v});
    if (rd && !wr) chk({tag, "_rdata"}, req_readdata, exp_rd);
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [1:0]  exp_wait [0:6];
  logic [1:0]  exp_rdv  [0:6];
  logic [31:0] exp_dat  [0:6];

  initial begin
    req_address    = '0;
    req_byteenable = '0;
    req_writedata  = '0;
    req_read       = '0;
    req_write      = '0;
    reset          = 1'b1;
    tick();
    tick();

    // Reset values.
    @(negedge clk);
    chk("rst_wait", {30'd0, req_waitrequest}, 32'h3);
    chk("rst_rdv", {30'd0, req_readdatavalid}, 32'h0);
    chk("rst_cs", {31'd0, ram_chipselect}, 32'h0);
    chk("rst_wr", {31'd0, ram_write}, 32'h0);
    tick();
    reset = 1'b0;

    // Write by requester 0, cycle by cycle.
    set_req(0, 1'b0, 1'b1, 13'h0010, 4'hF, 32'hA5A5_1234);
    @(negedge clk);
    chk("a_wait_idle", {30'd0, req_waitrequest}, 32'h3);
    tick();
    @(negedge clk);
    chk("a_wait_issue", {30'd0, req_waitrequest}, 32'h2);
    chk("a_cs", {31'd0, ram_chipselect}, 32'h1);
    chk("a_ramwr", {31'd0, ram_write}, 32'h1);
    chk("a_addr", {19'd0, ram_address}, 32'h0010);
    chk("a_wdata", ram_writedata, 32'hA5A5_1234);
    tick();
    req_write[0] = 1'b0;
    @(negedge clk);
    chk("a_no_resp", {30'd0, req_readdatavalid}, 32'h0);

    // Read back by requester 0, cycle by cycle.
    tick();
    set_req(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    @(negedge clk);
    chk("b_wait_idle", {30'd0, req_waitrequest}, 32'h3);
    tick();
    @(negedge clk);
    chk("b_wait_issue", {30'd0, req_waitrequest}, 32'h2);
    chk("b_cs", {31'd0, ram_chipselect}, 32'h1);
    chk("b_ramwr", {31'd0, ram_write}, 32'h0);
    tick();
    req_read[0] = 1'b0;
    @(negedge clk);
    chk("b_rdv", {30'd0, req_readdatavalid}, 32'h1);
    chk("b_rdata", req_readdata, 32'hA5A5_1234);
    tick();
    @(negedge clk);
    chk("b_rdv_gone", {30'd0, req_readdatavalid}, 32'h0);

    // Preload words 1 and 2; the last winner is requester 1.
    do_access("pre0", 0, 1'b0, 1'b1, 13'h0001, 4'hF, 32'h1111_1111, 1'b1, 32'h0);
    do_access("pre1", 1, 1'b0, 1'b1, 13'h0002, 4'hF, 32'h2222_2222, 1'b1, 32'h0);

    // Both requesters read continuously: grants 0,1,0 with one acceptance per two cycles.
    exp_wait = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11};
    exp_rdv  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_dat  = '{32'h0, 32'h0, 32'h1111_1111, 32'h0, 32'h2222_2222, 32'h0, 32'h1111_1111};
    tick();
    set_req(0, 1'b1, 1'b0, 13'h0001, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 13'h0002, 4'hF, 32'h0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("c_wait%0d", i), {30'd0, req_waitrequest}, {30'd0, exp_wait[i]});
      chk($sformatf("c_rdv%0d", i), {30'd0, req_readdatavalid}, {30'd0, exp_rdv[i]});
      if (exp_rdv[i] != 2'b00) chk($sformatf("c_rdata%0d", i), req_readdata, exp_dat[i]);
      tick();
    end
    // Requester 1 is granted next but drops its read during ISSUE.
    req_read = 2'b00;
    @(negedge clk);
    chk("c_drop_wait", {30'd0, req_waitrequest}, 32'h1);
    chk("c_drop_cs", {31'd0, ram_chipselect}, 32'h0);
    tick();
    @(negedge clk);
    chk("c_drop_rdv", {30'd0, req_readdatavalid}, 32'h0);

    // Byte-lane write.
    do_access("d_full", 1, 1'b0, 1'b1, 13'h0100, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0);
    do_access("d_lane", 1, 1'b0, 1'b1, 13'h0100, 4'b0100, 32'h00CC_0000, 1'b1, 32'h0);
    do_access("d_read", 1, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0, 1'b1, 32'hFFCC_FFFF);

    // Read and write together: write wins, no read response.
    do_access("e_rw", 0, 1'b1, 1'b1, 13'h0200, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0);
    do_access("e_read", 0, 1'b1, 1'b0, 13'h0200, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // Reset during the read-return cycle suppresses the valid pulse.
    tick();
    set_req(1, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0);
    @(negedge clk);
    chk("f_wait_idle", {30'd0, req_waitrequest}, 32'h3);
    tick();
    @(negedge clk);
    chk("f_wait_issue", {30'd0, req_waitrequest}, 32'h1);
    tick();
    reset       = 1'b1;
    req_read[1] = 1'b0;
    @(negedge clk);
    chk("f_rdv_supp", {30'd0, req_readdatavalid}, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("f_rdv_after", {30'd0, req_readdatavalid}, 32'h0);
    chk("f_wait_after", {30'd0, req_waitrequest}, 32'h3);
    // After reset requester 0 wins first even against requester 1.
    tick();
    set_req(0, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
    set_req(1, 1'b1, 1'b0, 13'h0100, 4'hF, 32'h0);
    @(negedge clk);
    chk("f_wait_idle2", {30'd0, req_waitrequest}, 32'h3);
    tick();
    @(negedge clk);
    chk("f_grant0", {30'd0, req_waitrequest}, 32'h2);
    tick();
    req_read = 2'b00;
    @(negedge clk);
    chk("f_rdv0", {30'd0, req_readdatavalid}, 32'h1);
    chk("f_rdata0", req_readdata, 32'hA5A5_1234);

`ifdef MON_SOPC_RAM_ARB_RANGE_CHK_EN
    // Range check: last valid word forwarded, first invalid word blocked.
    chk("g_err_init", {30'd0, range_err}, 32'h0);
    do_access("g_wr_top", 0, 1'b0, 1'b1, 13'h13FF, 4'hF, 32'h5A5A_0001, 1'b1, 32'h0);
    do_access("g_oor", 1, 1'b1, 1'b0, 13'h1400, 4'hF, 32'h0, 1'b0, 32'h0);
    chk("g_err_set", {30'd0, range_err}, 32'h2);
    do_access("g_rd_top", 0, 1'b1, 1'b0, 13'h13FF, 4'hF, 32'h0, 1'b1, 32'h5A5A_0001);
    chk("g_err_sticky", {30'd0, range_err}, 32'h2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
